pci_target_responder: RTL and testbench
=======================================

// Module: pci_target_responder
// PURPOSE
//  Target (responder) end of the shared-bus transaction protocol driven by the device initiators.
//  Decodes the address phase, claims matching transactions with devsel_n, then serves burst
//  reads from, or captures burst writes into, a local word memory with a trdy_n/irdy_n handshake.
//  Uses target disconnect (stop_n) when a burst would run past the end of memory. One instance per bus device.
// PARAMETERS
//  DEV_BASE   32'h0000_0100  device base; hit when ad_in[31:8]==DEV_BASE[31:8]
//  MEM_DEPTH  10             number of 32-bit words in local memory (<=256)
//  IDX_W      4              width of word index; must satisfy 2**IDX_W >= MEM_DEPTH
// PORTS
//  clk       in   1   clock; all activity on posedge
//  reset     in   1   reset, synchronous, active-high
//  frame_n   in   1   initiator frame, active-low
//  irdy_n    in   1   initiator ready, active-low
//  cbe       in   1   command at address phase: 1=read, 0=write
//  ad_in     in   32  address/data bus, sampled
//  ad_out    out  32  read data driven toward bus
//  ad_oe     out  1   1 = ad_out drives the shared bus
//  devsel_n  out  1   device select, active-low
//  trdy_n    out  1   target ready, active-low
//  stop_n    out  1   target disconnect request, active-low
//  ld_en     in   1   local preload strobe (bench/host side)
//  ld_idx    in   IDX_W  preload word index
//  ld_data   in   32  preload data
//  busy      out  1   1 whenever state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, devsel_n=1, trdy_n=1, stop_n=1, ad_oe=0, ad_out=0, busy=0; memory NOT cleared.
//  Reset asserted mid-transaction overrides everything; bus released the following cycle.
//  All outputs registered. Transfer = posedge with irdy_n==0 && trdy_n==0.
//  States: IDLE, SKIP, TURN, DATA, STOP, END.
//  IDLE: edge with frame_n==0 is the address phase; latch idx=ad_in[7:0], cmd=cbe.
//   hit (base match and ad_in[7:0]<MEM_DEPTH): read -> TURN, write -> DATA; devsel_n<=0.
//   miss -> SKIP. ld_en honoured only in IDLE: mem[ld_idx]<=ld_data (ld_idx>=MEM_DEPTH ignored).
//  SKIP: no outputs driven; return to IDLE on first edge with frame_n==1 && irdy_n==1.
//  TURN (read only): one bus turnaround cycle, ad_oe=0, trdy_n=1; next edge -> DATA with
//   ad_oe<=1, trdy_n<=0, ad_out<=mem[idx]. First read data on bus 2 cycles after address edge.
//  Write: DATA entered directly; trdy_n<=0 on address edge (zero wait states).
//  DATA: no transfer (irdy_n==1) -> hold ad_out/trdy_n unchanged (initiator wait state).
//   transfer: write stores mem[idx]<=ad_in; read presents ad_out<=mem[idx+1]; idx<=idx+1.
//   transfer with frame_n==1 (last data phase) -> END.
//   transfer with frame_n==0 and idx==MEM_DEPTH-1 -> STOP: trdy_n<=1, stop_n<=0, ad_oe<=0.
//  STOP: hold devsel_n=0, stop_n=0 until edge with frame_n==1 -> END.
//  END: devsel_n<=1, trdy_n<=1, stop_n<=1, ad_oe<=0; next edge -> IDLE (address phase
//   not accepted in END; back-to-back transactions need one idle cycle).
//  idx never wraps; memory index width IDX_W, ad_in[7:IDX_W] must be 0 for a hit.
// TESTING
//  1 preload mem[0..3]=A0..A3, read at DEV_BASE+0, 4 phases -> devsel_n low, ad_out A0..A3, END, IDLE.
//  2 write DEV_BASE+2 data 11,22,33 (3 phases) -> mem[2..4]=11,22,33; no turnaround, trdy_n low at addr edge+1.
//  3 read with irdy_n high 2 cycles in phase 2 -> ad_out holds mem[1], trdy_n stays low, no idx advance.
//  4 read from DEV_BASE+8, frame_n held low -> 2 transfers (mem[8],mem[9]) then stop_n=0 until frame_n=1.
//  5 address 32'h0000_0200 or DEV_BASE+10 -> devsel_n stays 1, ad_oe 0, SKIP until frame/irdy high.
//  6 reset asserted in DATA of a write burst -> all outputs at reset values next cycle, written words kept.

Source files
------------

// File: rtl/pci_target_responder.sv
// Bus target: claims address-decoded transactions and serves burst reads/writes
// from a local word memory, disconnecting with stop_n at the end of memory.
module pci_target_responder #(
    parameter logic [31:0] DEV_BASE  = 32'h0000_0100,
    parameter int unsigned MEM_DEPTH = 10,
    parameter int unsigned IDX_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_n,
    input  logic             irdy_n,
    input  logic             cbe,
    input  logic [31:0]      ad_in,
    output logic [31:0]      ad_out,
    output logic             ad_oe,
    output logic             devsel_n,
    output logic             trdy_n,
    output logic             stop_n,
    input  logic             ld_en,
    input  logic [IDX_W-1:0] ld_idx,
    input  logic [31:0]      ld_data,
    output logic             busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SKIP = 3'd1;
    localparam logic [2:0] S_TURN = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_STOP = 3'd4;
    localparam logic [2:0] S_END  = 3'd5;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_DEPTH - 1);

    logic [31:0]      mem_q [MEM_DEPTH];

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             cmd_q, cmd_d;
    logic [31:0]      ad_out_q, ad_out_d;
    logic             ad_oe_q, ad_oe_d;
    logic             devsel_n_q, devsel_n_d;
    logic             trdy_n_q, trdy_n_d;
    logic             stop_n_q, stop_n_d;
    logic             busy_q, busy_d;

    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [31:0]      mem_wdata;

    logic             addr_hit;
    logic             xfer;
    logic [IDX_W-1:0] idx_nxt;

    assign addr_hit = (ad_in[31:8] == DEV_BASE[31:8]) && (32'(ad_in[7:0]) < MEM_DEPTH);
    assign xfer     = !irdy_n && !trdy_n_q;
    assign idx_nxt  = idx_q + IDX_W'(1);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cmd_d      = cmd_q;
        ad_out_d   = ad_out_q;
        ad_oe_d    = ad_oe_q;
        devsel_n_d = devsel_n_q;
        trdy_n_d   = trdy_n_q;
        stop_n_d   = stop_n_q;
        mem_we     = 1'b0;
        mem_waddr  = ld_idx;
        mem_wdata  = ld_data;

        case (state_q)
            S_IDLE: begin
                if (ld_en && (32'(ld_idx) < MEM_DEPTH)) begin
                    mem_we = 1'b1;
                end
                if (!frame_n) begin
                    cmd_d = cbe;
                    idx_d = ad_in[IDX_W-1:0];
                    if (addr_hit) begin
                        devsel_n_d = 1'b0;
                        if (cbe) begin
                            state_d = S_TURN;
                        end else begin
                            state_d  = S_DATA;
                            trdy_n_d = 1'b0;
                        end
                    end else begin
                        state_d = S_SKIP;
                    end
                end
            end
            S_SKIP: begin
                if (frame_n && irdy_n) begin
                    state_d = S_IDLE;
                end
            end
            S_TURN: begin
                state_d  = S_DATA;
                ad_oe_d  = 1'b1;
                trdy_n_d = 1'b0;
                ad_out_d = mem_q[idx_q];
            end
            S_DATA: begin
                if (xfer) begin
                    if (cmd_q) begin
                        // Past the last word there is nothing to prefetch; the bus is released anyway.
                        ad_out_d = (idx_q == LAST_IDX) ? '0 : mem_q[idx_nxt];
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = idx_q;
                        mem_wdata = ad_in;
                    end
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_nxt;
                    end
                    if (frame_n) begin
                        state_d = S_END;
                    end else if (idx_q == LAST_IDX) begin
                        state_d  = S_STOP;
                        trdy_n_d = 1'b1;
                        stop_n_d = 1'b0;
                        ad_oe_d  = 1'b0;
                    end
                end
            end
            S_STOP: begin
                if (frame_n) begin
                    state_d = S_END;
                end
            end
            S_END: begin
                state_d    = S_IDLE;
                devsel_n_d = 1'b1;
                trdy_n_d   = 1'b1;
                stop_n_d   = 1'b1;
                ad_oe_d    = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (reset) begin
            mem_we = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cmd_q      <= 1'b0;
            ad_out_q   <= '0;
            ad_oe_q    <= 1'b0;
            devsel_n_q <= 1'b1;
            trdy_n_q   <= 1'b1;
            stop_n_q   <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cmd_q      <= cmd_d;
            ad_out_q   <= ad_out_d;
            ad_oe_q    <= ad_oe_d;
            devsel_n_q <= devsel_n_d;
            trdy_n_q   <= trdy_n_d;
            stop_n_q   <= stop_n_d;
            busy_q     <= busy_d;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign ad_out   = ad_out_q;
    assign ad_oe    = ad_oe_q;
    assign devsel_n = devsel_n_q;
    assign trdy_n   = trdy_n_q;
    assign stop_n   = stop_n_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_pci_target_responder.sv
// Drives the responder as a bus initiator with randomized bursts and compares
// against a word-array model of the target memory.
module tb_pci_target_responder;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          DEPTH = 10;

    logic        clk = 1'b0;
    logic        reset, frame_n, irdy_n, cbe, ld_en;
    logic [31:0] ad_in, ld_data, ad_out;
    logic [3:0]  ld_idx;
    logic        ad_oe, devsel_n, trdy_n, stop_n, busy;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_mem [DEPTH];

    pci_target_responder #(.DEV_BASE(BASE), .MEM_DEPTH(DEPTH), .IDX_W(4)) dut (
        .clk(clk), .reset(reset), .frame_n(frame_n), .irdy_n(irdy_n), .cbe(cbe),
        .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .devsel_n(devsel_n),
        .trdy_n(trdy_n), .stop_n(stop_n), .ld_en(ld_en), .ld_idx(ld_idx),
        .ld_data(ld_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_released(input string tag);
        chk({tag, "_devsel"}, devsel_n, 1);
        chk({tag, "_trdy"}, trdy_n, 1);
        chk({tag, "_stop"}, stop_n, 1);
        chk({tag, "_oe"}, ad_oe, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic preload(input int idx, input logic [31:0] data);
        ld_en = 1; ld_idx = 4'(idx); ld_data = data;
        tick();
        ld_en = 0;
        if (idx < DEPTH) model_mem[idx] = data;
    endtask

    // After the final data edge: either normal completion or a target disconnect.
    task automatic finish_txn(input bit stopped);
        if (stopped) begin
            chk("stop_asserted", stop_n, 0);
            chk("stop_trdy", trdy_n, 1);
            chk("stop_oe", ad_oe, 0);
            chk("stop_devsel", devsel_n, 0);
            irdy_n = 1;
            tick();
            chk("stop_hold", stop_n, 0);
            chk("stop_hold_devsel", devsel_n, 0);
            frame_n = 1;
            tick();
            chk("stop_end_busy", busy, 1);
            tick();
        end else begin
            irdy_n = 1; frame_n = 1;
            chk("end_busy", busy, 1);
            tick();
        end
        chk_released("done");
    endtask

    task automatic do_read(input int a, input int n, input int wph, input int wcyc);
        int avail, xfers;
        bit stopped;
        avail   = DEPTH - a;
        stopped = (n > avail);
        xfers   = stopped ? avail : n;
        frame_n = 0; cbe = 1; ad_in = BASE + 32'(a); irdy_n = 1;
        tick();
        chk("rd_claim", devsel_n, 0);
        chk("rd_turn_oe", ad_oe, 0);
        chk("rd_turn_trdy", trdy_n, 1);
        chk("rd_busy", busy, 1);
        irdy_n = 0; ad_in = $urandom;
        tick();
        for (int k = 0; k < xfers; k++) begin
            chk("rd_data", ad_out, model_mem[a + k]);
            chk("rd_trdy", trdy_n, 0);
            chk("rd_oe", ad_oe, 1);
            if (k == wph) begin
                for (int w = 0; w < wcyc; w++) begin
                    irdy_n = 1;
                    tick();
                    chk("rd_wait_data", ad_out, model_mem[a + k]);
                    chk("rd_wait_trdy", trdy_n, 0);
                end
            end
            irdy_n  = 0;
            frame_n = (k == n - 1);
            tick();
        end
        finish_txn(stopped);
    endtask

    task automatic do_write(input int a, input int n, input int wph, input int wcyc);
        int avail, xfers;
        bit stopped;
        logic [31:0] data;
        avail   = DEPTH - a;
        stopped = (n > avail);
        xfers   = stopped ? avail : n;
        frame_n = 0; cbe = 0; ad_in = BASE + 32'(a); irdy_n = 1;
        tick();
        chk("wr_claim", devsel_n, 0);
        chk("wr_trdy_now", trdy_n, 0);
        chk("wr_oe", ad_oe, 0);
        for (int k = 0; k < xfers; k++) begin
            data  = $urandom;
            ad_in = data;
            if (k == wph) begin
                for (int w = 0; w < wcyc; w++) begin
                    irdy_n = 1;
                    tick();
                    chk("wr_wait_trdy", trdy_n, 0);
                end
            end
            irdy_n  = 0;
            frame_n = (k == n - 1);
            tick();
            model_mem[a + k] = data;
        end
        finish_txn(stopped);
    endtask

    task automatic do_miss(input logic [31:0] addr);
        frame_n = 0; cbe = 1'($urandom); ad_in = addr; irdy_n = 1;
        tick();
        chk("miss_devsel", devsel_n, 1);
        chk("miss_oe", ad_oe, 0);
        chk("miss_trdy", trdy_n, 1);
        chk("miss_busy", busy, 1);
        irdy_n = 0; ld_en = 1; ld_idx = 0; ld_data = ~model_mem[0];
        tick();
        chk("skip_devsel", devsel_n, 1);
        frame_n = 1;
        tick();
        chk("skip_irdy_low", busy, 1);
        ld_en = 0; irdy_n = 1;
        tick();
        chk_released("skip_exit");
    endtask

    initial begin
        int a, n;
        logic [31:0] d0, d1;
        reset = 1; frame_n = 1; irdy_n = 1; cbe = 0; ad_in = 0;
        ld_en = 0; ld_idx = 0; ld_data = 0;
        tick(); tick();
        chk_released("reset");
        chk("reset_ad_out", ad_out, 0);
        reset = 0;
        tick();

        for (int i = 0; i < DEPTH; i++) preload(i, $urandom);
        for (int i = DEPTH; i < 16; i++) preload(i, $urandom);

        do_read(0, 4, 0, 0);
        do_write(2, 3, 0, 0);
        do_read(0, 6, 0, 0);
        do_read(0, 4, 1, 2);
        do_read(8, 5, 0, 0);
        do_miss(32'h0000_0200);
        do_miss(BASE + 32'd10);
        do_miss(BASE + 32'h12);
        do_write(7, 5, 1, 1);
        do_read(5, DEPTH, 0, 0);

        for (int r = 0; r < 8; r++) begin
            a = int'($urandom_range(0, DEPTH - 1));
            n = int'($urandom_range(1, 5));
            if ($urandom_range(0, 1) == 1)
                do_read(a, n, int'($urandom_range(0, n - 1)), int'($urandom_range(0, 2)));
            else
                do_write(a, n, int'($urandom_range(0, n - 1)), int'($urandom_range(0, 2)));
        end

        // Reset during a write burst: two words land, the one at the reset edge does not.
        d0 = $urandom; d1 = $urandom;
        frame_n = 0; cbe = 0; ad_in = BASE + 32'd3; irdy_n = 1;
        tick();
        ad_in = d0; irdy_n = 0;
        tick();
        ad_in = d1;
        tick();
        model_mem[3] = d0; model_mem[4] = d1;
        ad_in = ~model_mem[5]; reset = 1;
        tick();
        chk_released("midreset");
        chk("midreset_ad_out", ad_out, 0);
        reset = 0; frame_n = 1; irdy_n = 1;
        tick();
        chk_released("post_reset");
        do_read(3, 3, 0, 0);
        do_read(0, DEPTH, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
